sdram_arbit: RTL and testbench



---
 rtl/sdram_arbit.sv | 188 ++++++++++++++++++
 tb/tb_sdram_arbit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
//
// Owns the SDRAM command/address bus. After power-up it passes the
// initialisation sequencer through to the pins. Once that sequence reports
// completion, it grants the bus to one requester at a time with the fixed
// priority refresh > write > read. A watchdog flags refresh requests that
// wait too long for their grant.
//
// Ports
//   CLK, RSTn                 clock, asynchronous active-low reset
//   init_cmd/init_addr        init sequencer command {cs_n,ras_n,cas_n,we_n}/address
//   flag_init_end             level, init sequence complete
//   ref_req/wr_req/rd_req     request levels, held until granted
//   flag_ref_end/_wr_end/_rd_end  one-cycle "operation done" pulses
//   aref_*/wr_*/rd_*          command/address from each requester
//   ref_en/wr_en/rd_en        one-cycle registered grant pulses
//   sdram_cmd/sdram_addr      selected command/address
//   sdram_cs_n.._we_n         decoded sdram_cmd bits 3..0
//   ref_late                  refresh grant overdue
// -----------------------------------------------------------------------------
module sdram_arbit #(
  parameter int unsigned REF_WAIT_MAX = 100
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        flag_init_end,
  input  logic        ref_req,
  input  logic        flag_ref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [11:0] aref_addr,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic        flag_wr_end,
  input  logic        flag_rd_end,
  input  logic [3:0]  wr_cmd,
  input  logic [3:0]  rd_cmd,
  input  logic [11:0] wr_addr,
  input  logic [11:0] rd_addr,
  output logic        ref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic        ref_late
);

  localparam logic [3:0] CMD_NOP      = 4'b0111;
  localparam logic [9:0] WAIT_LIMIT   = 10'(REF_WAIT_MAX);
  localparam logic [9:0] WAIT_SAT     = 10'h3FF;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } state_e;

  state_e      state_q, state_d;
  logic        ref_en_q, ref_en_d;
  logic        wr_en_q, wr_en_d;
  logic        rd_en_q, rd_en_d;
  logic [9:0]  ref_wait_cnt_q, ref_wait_cnt_d;
  logic        ref_late_q, ref_late_d;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q        <= ST_INIT;
      ref_en_q       <= 1'b0;
      wr_en_q        <= 1'b0;
      rd_en_q        <= 1'b0;
      ref_wait_cnt_q <= 10'd0;
      ref_late_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ref_en_q       <= ref_en_d;
      wr_en_q        <= wr_en_d;
      rd_en_q        <= rd_en_d;
      ref_wait_cnt_q <= ref_wait_cnt_d;
      ref_late_q     <= ref_late_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Grant pulses are only produced on the ARBIT exit edge,
  // so they land in the first cycle of the granted state and cannot repeat.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    ref_en_d = 1'b0;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (flag_init_end) state_d = ST_ARBIT;
      end
      ST_ARBIT: begin
        if (ref_req) begin
          state_d  = ST_AREF;
          ref_en_d = 1'b1;
        end else if (wr_req) begin
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
        end else if (rd_req) begin
          state_d = ST_READ;
          rd_en_d = 1'b1;
        end
      end
      ST_AREF: begin
        if (flag_ref_end) state_d = ST_ARBIT;
      end
      ST_WRITE: begin
        if (flag_wr_end) state_d = ST_ARBIT;
      end
      ST_READ: begin
        if (flag_rd_end) state_d = ST_ARBIT;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Refresh watchdog. The count runs whenever refresh is wanted but not being
  // served; the late flag is sticky until the refresh grant, and the grant
  // wins over a same-edge set.
  // ---------------------------------------------------------------------------
  always_comb begin
    ref_wait_cnt_d = 10'd0;
    if (ref_req && (state_q != ST_AREF)) begin
      ref_wait_cnt_d = (ref_wait_cnt_q == WAIT_SAT) ? ref_wait_cnt_q
                                                     : ref_wait_cnt_q + 10'd1;
    end

    ref_late_d = ref_late_q;
    if (ref_wait_cnt_q == WAIT_LIMIT) ref_late_d = 1'b1;
    if (ref_en_d)                     ref_late_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Bus mux, purely from the current state.
  // ---------------------------------------------------------------------------
  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = 12'h000;
    case (state_q)
      ST_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      ST_AREF: begin
        sdram_cmd  = aref_cmd;
        sdram_addr = aref_addr;
      end
      ST_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
      end
      ST_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = 12'h000;
      end
    endcase
  end

  assign ref_en      = ref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign ref_late    = ref_late_q;
  assign sdram_cs_n  = sdram_cmd[3];
  assign sdram_ras_n = sdram_cmd[2];
  assign sdram_cas_n = sdram_cmd[1];
  assign sdram_we_n  = sdram_cmd[0];

endmodule

// File: tb/tb_sdram_arbit.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbit
//
// Bench for sdram_arbit with REF_WAIT_MAX = 8: a cycle-by-cycle vector table,
// hand-written sequences for the watchdog and mid-operation reset, then a
// randomized run checked against a bus-ownership model.
// -----------------------------------------------------------------------------
module tb_sdram_arbit;

  localparam int M = 8;

  logic        CLK, RSTn;
  logic [3:0]  init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [11:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic        flag_init_end, ref_req, wr_req, rd_req;
  logic        flag_ref_end, flag_wr_end, flag_rd_end;
  logic        ref_en, wr_en, rd_en, ref_late;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  sdram_arbit #(.REF_WAIT_MAX(M)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .init_cmd(init_cmd), .init_addr(init_addr), .flag_init_end(flag_init_end),
    .ref_req(ref_req), .flag_ref_end(flag_ref_end),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .rd_req(rd_req),
    .flag_wr_end(flag_wr_end), .flag_rd_end(flag_rd_end),
    .wr_cmd(wr_cmd), .rd_cmd(rd_cmd), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .ref_late(ref_late)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------------------------------------------------------------------
  // Reference model: who owns the bus, which grant was just issued, and how
  // long refresh has been waiting.
  // ---------------------------------------------------------------------------
  bit m_ready;   // init sequence finished
  int m_job;     // -1 nobody, 0 refresh, 1 write, 2 read
  int m_pulse;   // job granted at the last edge, -1 if none
  int m_wait;
  bit m_late;

  task automatic model_step();
    int nwait;
    bit done;
    if (!RSTn) begin
      m_ready = 0; m_job = -1; m_pulse = -1; m_wait = 0; m_late = 0;
      return;
    end
    nwait = (ref_req && m_job != 0) ? ((m_wait < 1023) ? m_wait + 1 : 1023) : 0;
    m_pulse = -1;
    if (!m_ready) begin
      m_ready = flag_init_end;
    end else if (m_job < 0) begin
      if (ref_req)     m_job = 0;
      else if (wr_req) m_job = 1;
      else if (rd_req) m_job = 2;
      m_pulse = m_job;
    end else begin
      done = (m_job == 0 && flag_ref_end) || (m_job == 1 && flag_wr_end) ||
             (m_job == 2 && flag_rd_end);
      if (done) m_job = -1;
    end
    if (m_pulse == 0)   m_late = 0;
    else if (m_wait == M) m_late = 1;
    m_wait = nwait;
  endtask

  // One clock: model follows the edge, outputs are looked at 1 ns later.
  task automatic tick();
    @(posedge CLK);
    model_step();
    cycle++;
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] en, input logic late,
                     input logic [3:0] cmd, input logic [11:0] addr);
    logic [23:0] act, exp;
    act = {ref_en, wr_en, rd_en, ref_late, sdram_cmd, sdram_addr,
           sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    exp = {en, late, cmd, addr, cmd};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got en=%b late=%b cmd=%h addr=%h pins=%b, want en=%b late=%b cmd=%h addr=%h",
               name, cycle, act[23:21], act[20], act[19:16], act[15:4], act[3:0],
               en, late, cmd, addr);
    end
  endtask

  task automatic chk_model(input string name);
    logic [3:0]  cmd;
    logic [11:0] addr;
    if (!m_ready)        begin cmd = init_cmd; addr = init_addr; end
    else if (m_job == 0) begin cmd = aref_cmd; addr = aref_addr; end
    else if (m_job == 1) begin cmd = wr_cmd;   addr = wr_addr;   end
    else if (m_job == 2) begin cmd = rd_cmd;   addr = rd_addr;   end
    else                 begin cmd = 4'b0111;  addr = 12'h000;   end
    chk(name, {m_pulse == 0, m_pulse == 1, m_pulse == 2}, m_late, cmd, addr);
  endtask

  // {init_end, ref_req, wr_req, rd_req, ref_end, wr_end, rd_end}
  task automatic drive(input logic [6:0] v);
    {flag_init_end, ref_req, wr_req, rd_req, flag_ref_end, flag_wr_end, flag_rd_end} = v;
  endtask

  typedef struct {
    logic [6:0]  in;
    logic [2:0]  en;   // {ref, wr, rd}
    logic [3:0]  cmd;
    logic [11:0] addr;
  } vec_t;

  vec_t tbl[17];

  initial begin
    // Fixed per-source command/address so ownership is visible on the bus.
    init_cmd = 4'h2; init_addr = 12'h111;
    aref_cmd = 4'h1; aref_addr = 12'h222;
    wr_cmd   = 4'h4; wr_addr   = 12'h333;
    rd_cmd   = 4'h5; rd_addr   = 12'h444;

    //            in          en      cmd    addr     (state after the edge)
    tbl[0]  = '{7'b0000000, 3'b000, 4'h2, 12'h111}; // INIT
    tbl[1]  = '{7'b0010000, 3'b000, 4'h2, 12'h111}; // wr_req ignored in INIT
    tbl[2]  = '{7'b1010000, 3'b000, 4'h7, 12'h000}; // ARBIT
    tbl[3]  = '{7'b0010000, 3'b010, 4'h4, 12'h333}; // WRITE grant
    tbl[4]  = '{7'b0101000, 3'b000, 4'h4, 12'h333}; // ref/rd wait, no preemption
    tbl[5]  = '{7'b0101001, 3'b000, 4'h4, 12'h333}; // stray rd_end ignored
    tbl[6]  = '{7'b0101010, 3'b000, 4'h7, 12'h000}; // wr_end -> ARBIT
    tbl[7]  = '{7'b0101000, 3'b100, 4'h1, 12'h222}; // ref beats rd
    tbl[8]  = '{7'b0001001, 3'b000, 4'h1, 12'h222}; // stray rd_end in AREF
    tbl[9]  = '{7'b0001100, 3'b000, 4'h7, 12'h000}; // ref_end -> ARBIT
    tbl[10] = '{7'b0001000, 3'b001, 4'h5, 12'h444}; // READ grant
    tbl[11] = '{7'b0010010, 3'b000, 4'h5, 12'h444}; // stray wr_end in READ
    tbl[12] = '{7'b0010001, 3'b000, 4'h7, 12'h000}; // rd_end -> ARBIT
    tbl[13] = '{7'b0010000, 3'b010, 4'h4, 12'h333}; // WRITE grant
    tbl[14] = '{7'b0000000, 3'b000, 4'h4, 12'h333};
    tbl[15] = '{7'b0000010, 3'b000, 4'h7, 12'h000};
    tbl[16] = '{7'b0000000, 3'b000, 4'h7, 12'h000};

    // ---- reset ----
    RSTn = 1'b0;
    drive(7'b0);
    tick(); tick();
    chk("reset", 3'b000, 1'b0, 4'h2, 12'h111);
    RSTn = 1'b1;

    // ---- vector table ----
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].in);
      tick();
      chk($sformatf("vec%0d", i), tbl[i].en, 1'b0, tbl[i].cmd, tbl[i].addr);
    end
    drive(7'b0);

    // ---- watchdog: ref_req rises during a long write ----
    wr_req = 1'b1;
    tick();
    chk("wd_wr_grant", 3'b010, 1'b0, 4'h4, 12'h333);
    wr_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    ref_req = 1'b1;                       // rises after this edge
    for (int k = 1; k <= M; k++) tick();
    chk("wd_not_yet", 3'b000, 1'b0, 4'h4, 12'h333);
    tick();
    chk("wd_late_set", 3'b000, 1'b1, 4'h4, 12'h333);
    for (int k = 0; k < 16; k++) tick();
    chk("wd_late_hold", 3'b000, 1'b1, 4'h4, 12'h333);
    flag_wr_end = 1'b1;
    tick();
    chk("wd_arbit", 3'b000, 1'b1, 4'h7, 12'h000);
    flag_wr_end = 1'b0;
    tick();
    chk("wd_clear_on_grant", 3'b100, 1'b0, 4'h1, 12'h222);
    ref_req = 1'b0;
    tick();
    flag_ref_end = 1'b1;
    tick();
    chk("wd_ref_done", 3'b000, 1'b0, 4'h7, 12'h000);
    flag_ref_end = 1'b0;

    // ---- reset in the middle of a read ----
    rd_req = 1'b1;
    tick();
    chk("rst_rd_grant", 3'b001, 1'b0, 4'h5, 12'h444);
    RSTn = 1'b0;
    #1;
    chk("rst_async", 3'b000, 1'b0, 4'h2, 12'h111);
    tick();
    RSTn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("rst_hold%0d", k), 3'b000, 1'b0, 4'h2, 12'h111);
    end
    flag_init_end = 1'b1;
    tick();
    chk("rst_reinit", 3'b000, 1'b0, 4'h7, 12'h000);
    flag_init_end = 1'b0;                 // dropping it later changes nothing
    tick();
    chk("rst_rd_regrant", 3'b001, 1'b0, 4'h5, 12'h444);
    rd_req = 1'b0;
    flag_rd_end = 1'b1;
    tick();
    chk("rst_rd_done", 3'b000, 1'b0, 4'h7, 12'h000);
    flag_rd_end = 1'b0;

    // ---- randomized run against the model ----
    for (int n = 0; n < 2000; n++) begin
      // requests hold until the model says they were granted
      if (m_pulse == 0)           ref_req = 1'b0;
      else if ($urandom % 6 == 0) ref_req = 1'b1;
      if (m_pulse == 1)           wr_req = 1'b0;
      else if ($urandom % 6 == 0) wr_req = 1'b1;
      if (m_pulse == 2)           rd_req = 1'b0;
      else if ($urandom % 6 == 0) rd_req = 1'b1;
      flag_ref_end  = ($urandom % 8 == 0);
      flag_wr_end   = ($urandom % 8 == 0);
      flag_rd_end   = ($urandom % 8 == 0);
      flag_init_end = ($urandom % 4 != 0);
      RSTn          = (RSTn && ($urandom % 400 == 0)) ? 1'b0 : 1'b1;
      init_cmd  = 4'($urandom); init_addr = 12'($urandom);
      aref_cmd  = 4'($urandom); aref_addr = 12'($urandom);
      wr_cmd    = 4'($urandom); wr_addr   = 12'($urandom);
      rd_cmd    = 4'($urandom); rd_addr   = 12'($urandom);
      tick();
      if (m_pulse >= 0)
        $display("grant %s at cycle %0d", (m_pulse == 0) ? "refresh" :
                 (m_pulse == 1) ? "write" : "read", cycle);
      chk_model("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
